// File: rtl/cobalt_iq_pkg.sv
// Shared types for the integer issue queue: entry layout, default widths and
// the occupancy-width helper.
package cobalt_iq_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rs_valid;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic              rt_valid;
  } iq_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iq_slot.sv
// One issue-queue entry: selects hold / shift-in / dispatch write / clear,
// then applies CDB wakeup to whichever entry lands in the slot.
module iq_slot
  import cobalt_iq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  iq_entry_t           wr_entry,
  input  logic                shift_en,
  input  logic                shift_in_valid,
  input  iq_entry_t           shift_in,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DATA_W-1:0]   cdb_data,
  output logic                valid_q,
  output iq_entry_t           entry_q
);

  logic      valid_d;
  iq_entry_t entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    // Write beats shift: a same-cycle dispatch lands on the slot vacated by the shift.
    if (clr) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
      entry_d = wr_entry;
    end else if (shift_en) begin
      valid_d = shift_in_valid;
      entry_d = shift_in;
    end
    if (valid_d && cdb_valid) begin
      if (!entry_d.rs_valid && (entry_d.rs_tag == cdb_tag)) begin
        entry_d.rs_valid = 1'b1;
        entry_d.rs_data  = cdb_data;
      end
      if (!entry_d.rt_valid && (entry_d.rt_tag == cdb_tag)) begin
        entry_d.rt_valid = 1'b1;
        entry_d.rt_data  = cdb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/issue_queue_int.sv
// Collapsing, age-ordered integer issue queue with CDB wakeup and oldest-ready
// select. Optional flush port and logic enabled by defining IQ_FLUSH_EN.
module issue_queue_int #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cobalt_iq_pkg::DATA_W,
  parameter int TAG_W  = cobalt_iq_pkg::TAG_W,
  parameter int INST_W = cobalt_iq_pkg::INST_W,
  localparam int OCC_W = cobalt_iq_pkg::occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_en,
  input  logic [INST_W-1:0] dispatch_inst,
  input  logic [DATA_W-1:0] dispatch_rs_data,
  input  logic [DATA_W-1:0] dispatch_rt_data,
  input  logic [TAG_W-1:0]  dispatch_rs_tag,
  input  logic [TAG_W-1:0]  dispatch_rt_tag,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  output logic              dispatch_ready,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [INST_W-1:0] issue_inst,
  output logic [DATA_W-1:0] issue_rs_data,
  output logic [DATA_W-1:0] issue_rt_data,
  output logic [TAG_W-1:0]  issue_rd_tag,
`ifdef IQ_FLUSH_EN
  input  logic              flush,
`endif
  output logic [OCC_W-1:0]  occupancy
);

  import cobalt_iq_pkg::iq_entry_t;

  localparam int IDX_W = $clog2(DEPTH);

  // Handshakes: dispatch transfers when dispatch_en && dispatch_ready; issue
  // transfers when issue_valid && issue_ready; both complete at the next edge.
  logic [DEPTH-1:0] valid_q, rdy, shift_en, wr_en;
  iq_entry_t        entry_q [DEPTH];
  iq_entry_t        disp_entry;
  logic [OCC_W-1:0] count_q, count_d, wr_idx;
  logic [IDX_W-1:0] sel;
  logic             found, do_issue, do_disp, clr;

`ifdef IQ_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    disp_entry          = '0;
    disp_entry.inst     = dispatch_inst;
    disp_entry.rd_tag   = dispatch_rd_tag;
    disp_entry.rs_tag   = dispatch_rs_tag;
    disp_entry.rs_data  = dispatch_rs_data;
    disp_entry.rs_valid = dispatch_rsvalid;
    disp_entry.rt_tag   = dispatch_rt_tag;
    disp_entry.rt_data  = dispatch_rt_data;
    disp_entry.rt_valid = dispatch_rtvalid;
  end

  // Priority select: scanning downward leaves sel on the lowest ready slot.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign issue_valid    = found && !rst && !clr;
  assign issue_inst     = entry_q[sel].inst;
  assign issue_rs_data  = entry_q[sel].rs_data;
  assign issue_rt_data  = entry_q[sel].rt_data;
  assign issue_rd_tag   = entry_q[sel].rd_tag;
  assign dispatch_ready = !rst && (count_q != OCC_W'(DEPTH));
  assign do_issue       = issue_valid && issue_ready;
  assign do_disp        = dispatch_en && dispatch_ready && !clr;
  assign wr_idx         = do_issue ? (count_q - OCC_W'(1)) : count_q;
  assign occupancy      = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (do_disp && !do_issue) begin
      count_d = count_q + OCC_W'(1);
    end else if (do_issue && !do_disp) begin
      count_d = count_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    iq_entry_t nxt_entry;
    logic      nxt_valid;
    if (g < DEPTH - 1) begin : g_mid
      assign nxt_entry = entry_q[g+1];
      assign nxt_valid = valid_q[g+1];
    end else begin : g_last
      assign nxt_entry = '0;
      assign nxt_valid = 1'b0;
    end
    assign rdy[g]      = valid_q[g] && entry_q[g].rs_valid && entry_q[g].rt_valid;
    assign shift_en[g] = do_issue && (IDX_W'(g) >= sel);
    assign wr_en[g]    = do_disp && (wr_idx == OCC_W'(g));

    iq_slot u_slot (
      .clk            (clk),
      .rst            (rst),
      .clr            (clr),
      .wr_en          (wr_en[g]),
      .wr_entry       (disp_entry),
      .shift_en       (shift_en[g]),
      .shift_in_valid (nxt_valid),
      .shift_in       (nxt_entry),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_data       (cdb_data),
      .valid_q        (valid_q[g]),
      .entry_q        (entry_q[g])
    );
  end

  a_no_dispatch_when_full : assert property (
    @(posedge clk) disable iff (rst) !(dispatch_en && !dispatch_ready)
  );

endmodule

// File: doc/issue_queue_int.md
# issue_queue_int

Parametrised integer issue queue for the out-of-order core. It sits between dispatch and the integer ALU, and holds up to DEPTH instructions. Each entry snoops the CDB until its rs and rt operands are both valid. Each cycle the queue issues the oldest ready entry to the ALU under a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4: number of entries; legal range 2..16.
- DATA_W, 32: operand and CDB data width.
- TAG_W, 6: ROB/rename tag width.
- INST_W, 32: instruction word width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- dispatch_en  in  1  writes an entry this cycle; legal only while dispatch_ready=1.
- dispatch_inst  in  INST_W  instruction word.
- dispatch_rs_data / dispatch_rt_data  in  DATA_W  operand values.
- dispatch_rs_tag / dispatch_rt_tag  in  TAG_W  producer tags.
- dispatch_rsvalid / dispatch_rtvalid  in  1  operand value already valid.
- dispatch_rd_tag  in  TAG_W  destination tag.
- dispatch_ready  out  1  queue can accept an entry.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB broadcast tag.
- cdb_data  in  DATA_W  CDB broadcast data.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  ALU accepts the issued entry.
- issue_inst  out  INST_W  issued instruction.
- issue_rs_data / issue_rt_data  out  DATA_W  issued operand values.
- issue_rd_tag  out  TAG_W  issued destination tag.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.
- flush  in  1  present only with IQ_FLUSH_EN.

## Operation
- **Storage:** collapsing, age-ordered queue. Slot 0 is the oldest entry. Valid slots are always contiguous from slot 0.
- **Entry contents:** inst, rd_tag, and for each of rs and rt: tag, data, valid.
- **Wakeup:** when cdb_valid=1, every valid entry with an unready source whose tag equals cdb_tag captures cdb_data and sets that source valid.
  - Wakeup also applies to the entry being dispatched in the same cycle.
  - Wakeup also applies to entries shifting down in the same cycle.
- **Select:** the lowest-index valid slot with both sources valid.
  - issue_valid=1 when such a slot exists.
  - The issue_* outputs carry that slot's fields.
  - issue_* outputs are combinational from registered state only; there is no path from dispatch or CDB inputs.
- **Issue:** when issue_valid && issue_ready, the selected slot k is removed. Slots k+1..count-1 shift down by one.
- **Dispatch:** the new entry is written at slot count, or count-1 if an issue occurs in the same cycle.
- **Dispatch ready:** dispatch_ready = !rst && (occupancy != DEPTH). It does not account for an issue in the same cycle.
- **Occupancy:** +1 on dispatch only, −1 on issue only, unchanged on both or neither.
- **dispatch_en while dispatch_ready=0:** ignored, with no state change. A simulation assertion flags it.
- **Reset:** every slot is invalidated and occupancy=0. issue_valid=0, dispatch_ready=0 while rst=1. dispatch_ready=1 on the first cycle after rst deasserts.
- **Reset mid-operation:** all queued entries are discarded. Nothing is issued in the reset cycle.

## Timing
- Dispatch to earliest issue: an entry dispatched in cycle N with both operands valid is visible on issue_* in cycle N+1.
- CDB wakeup to issue: a broadcast in cycle N makes the entry eligible in N+1.
- Dispatch and CDB broadcast matching a source tag in the same cycle: the operand is captured, and the entry is eligible in N+1.
- Issue handshake: the removal and shift complete at the edge ending the handshake cycle. The next-oldest ready entry is presented in the following cycle.
- With issue_ready held high and a queue of ready entries, throughput is one issue per cycle.
- Full queue: dispatch_ready=0 for the whole cycle, even if an issue occurs in that cycle.

## Configuration
- IQ_FLUSH_EN defined:
  - The flush port exists.
  - flush=1 invalidates all entries and sets occupancy=0 at the next edge.
  - flush overrides dispatch and issue in the same cycle.
  - issue_valid is forced to 0 while flush=1.
- IQ_FLUSH_EN undefined: the flush port and its logic are absent. Entries leave the queue only by issue or rst.

## Structure
- Shared package cobalt_iq_pkg holds:
  - the iq_entry_t struct (inst, rd_tag, rs/rt tag, data, valid), parametrised via package constants;
  - default widths (DATA_W, TAG_W, INST_W);
  - an occupancy-width helper.
- Sub-module iq_slot holds one entry register. It has mux inputs for hold, shift-in from slot k+1, dispatch write, and clear, plus per-source CDB tag compare and capture.
- The top level instantiates DEPTH iq_slots, a priority select (lowest ready index), the shift-enable decode, and the occupancy counter.

## Test plan
- **Reset and first dispatch:** after reset, dispatch one entry with rsvalid=rtvalid=1 and rd_tag=5 → issue_valid=1 next cycle, issue_rd_tag=5, occupancy=1. It is removed on handshake and occupancy returns to 0.
- **Wakeup:** dispatch with rs_tag=3 unready; broadcast cdb_tag=3, cdb_data=0xDEADBEEF two cycles later → issue_valid rises the cycle after the broadcast, with issue_rs_data=0xDEADBEEF.
- **Same-cycle bypass:** dispatch with rt_tag=7 unready while cdb_valid=1, cdb_tag=7 → the entry issues the next cycle with rt_data equal to the CDB data.
- **Oldest-ready order:** fill DEPTH=4 with entries A(blocked), B, C, D(ready), issue_ready=1 → issue order B, C, D. A issues after its wakeup. dispatch_ready=0 while full.
- **Shift plus dispatch:** issue slot 1 while dispatching in the same cycle → occupancy unchanged, order preserved, and a CDB wakeup to the shifting slot is captured.
- **Flush (IQ_FLUSH_EN):** 3 entries plus flush=1 with dispatch_en=1 and issue_ready=1 → no issue, occupancy=0 next cycle, dispatch_ready=1.
